// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : piso_pkg
//  Brief    : Shared state encoding and width limits for the PISO serializer.
//  Revision : 1.0 - initial release
// ============================================================================

package piso_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MIN_WIDTH = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage : piso_pkg

`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer_if
//  Brief    : Parallel-load / serial-out bundle between a word source and the
//             serializer. The master drives words and shift enables.
//  Revision : 1.0 - initial release
// ============================================================================

interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    import piso_pkg::*;

    logic             load;
    logic [WIDTH-1:0] parallel_in;
    logic             msb_first;
    logic             load_ready;
    logic             shift;
    logic             serial_out;
    logic             serial_valid;
    logic             last;
    logic             busy;

    modport master (
        output load,
        output parallel_in,
        output msb_first,
        output shift,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  last,
        input  busy
    );

    modport slave (
        input  load,
        input  parallel_in,
        input  msb_first,
        input  shift,
        output load_ready,
        output serial_out,
        output serial_valid,
        output last,
        output busy
    );

endinterface : piso_serializer_if

`default_nettype wire

// File: rtl/piso_serializer_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bit_counter
//  Brief    : Modulo-MODULUS up counter with synchronous clear and a
//             terminal-count flag raised when the count equals MODULUS-1.
//  Revision : 1.0 - initial release
// ============================================================================

module bit_counter
    import piso_pkg::*;
#(
    parameter int MODULUS = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear_i,
    input  wire logic inc_i,
    output logic      tc_o
);

    localparam int            CW   = $clog2(MODULUS);
    localparam logic [CW-1:0] c_TC = CW'(MODULUS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            // Explicit wrap keeps the count below MODULUS for non-power-of-two widths
            count_d = (count_q == c_TC) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == c_TC);

endmodule : bit_counter

`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Brief    : Parallel-in serial-out shifter with per-word bit order, stall
//             support and gap-free back-to-back frames.
//  Revision : 1.0 - initial release
// ============================================================================

module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    piso_serializer_if.slave bus
);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("piso_serializer: WIDTH out of range");
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             order_q;
    logic             order_d;
    logic             sout_q;
    logic             sout_d;
    logic             svalid_q;
    logic             svalid_d;
    logic             last_q;
    logic             last_d;

    logic             w_tc;
    logic             w_shift_en;
    logic             w_ready;
    logic             w_accept;

    assign w_shift_en = (state_q == SHIFT) && bus.shift;
    assign w_ready    = (state_q == IDLE) || (w_shift_en && w_tc);
    assign w_accept   = bus.load && w_ready;

    bit_counter #(
        .MODULUS (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (w_accept),
        .inc_i   (w_shift_en),
        .tc_o    (w_tc)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        order_d  = order_q;
        sout_d   = sout_q;
        svalid_d = 1'b0;
        last_d   = 1'b0;

        if (w_shift_en) begin
            svalid_d = 1'b1;
            last_d   = w_tc;
            if (order_q) begin
                sout_d  = shreg_q[WIDTH-1];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                sout_d  = shreg_q[0];
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            if (w_tc) begin
                state_d = IDLE;
            end
        end

        // A load on the final-bit cycle overrides the return to IDLE
        if (w_accept) begin
            shreg_d = bus.parallel_in;
            order_d = bus.msb_first;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            order_q  <= 1'b0;
            sout_q   <= IDLE_LEVEL;
            svalid_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            order_q  <= order_d;
            sout_q   <= sout_d;
            svalid_q <= svalid_d;
            last_q   <= last_d;
        end
    end

    assign bus.load_ready   = w_ready;
    assign bus.serial_out   = sout_q;
    assign bus.serial_valid = svalid_q;
    assign bus.last         = last_q;
    assign bus.busy         = (state_q == SHIFT);

endmodule : piso_serializer

`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits, legal range 2..64.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b0, value driven on serial_out after reset and while no frame has been shifted.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port load, input, 1, parallel word valid.
REQ-006 SHALL have port parallel_in, input, WIDTH, word to serialise.
REQ-007 SHALL have port msb_first, input, 1, bit order for the word being accepted (1 = MSB first, 0 = LSB first).
REQ-008 SHALL have port load_ready, output, 1, block can accept a word this cycle.
REQ-009 SHALL have port shift, input, 1, shift enable; one bit is emitted per cycle with shift=1.
REQ-010 SHALL have port serial_out, output, 1, registered serial bit.
REQ-011 SHALL have port serial_valid, output, 1, serial_out carries a new bit this cycle.
REQ-012 SHALL have port last, output, 1, serial_out is the final bit of the frame; qualified by serial_valid.
REQ-013 SHALL have port busy, output, 1, a frame is held and not fully shifted.

Function
REQ-014 SHALL implement two states: IDLE and SHIFT.
REQ-015 Accept SHALL occur on a rising edge with load=1 and load_ready=1; it captures parallel_in, latches msb_first and clears the bit counter.
REQ-016 Accept SHALL move IDLE to SHIFT.
REQ-017 load_ready SHALL be 1 in IDLE, and in SHIFT only when shift=1 and the counter equals WIDTH-1; it is 0 otherwise.
REQ-018 load with load_ready=0 SHALL be ignored, with no change to the held word.
REQ-019 In SHIFT with shift=1, the next edge SHALL register:
- serial_out = shreg[0] (LSB mode) or shreg[WIDTH-1] (MSB mode);
- serial_valid = 1;
- the shift register moves one position toward the emitted end;
- the counter increments.
REQ-020 last SHALL be registered to 1 together with the bit emitted when the counter was WIDTH-1, and SHALL be 0 otherwise.
REQ-021 After the final bit, the state SHALL return to IDLE, or SHALL stay in SHIFT with the counter at 0 when an accept occurs in the same cycle, giving back-to-back frames with no gap.
REQ-022 In SHIFT with shift=0, the next edge SHALL register serial_valid=0 and last=0 and SHALL hold serial_out, the shift register and the counter (stall).
REQ-023 shift in IDLE SHALL have no effect; serial_valid and last register 0 and serial_out holds its value.
REQ-024 Latency SHALL be as follows:
- the first bit appears one cycle after the first shift=1 edge following the accept edge;
- a frame takes exactly WIDTH shift=1 cycles.
REQ-025 busy SHALL equal (state==SHIFT).
REQ-026 A changing msb_first mid-frame SHALL NOT affect the frame in progress.
REQ-027 The counter width SHALL be $clog2(WIDTH) and SHALL never exceed WIDTH-1.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, shreg=0, counter=0, serial_out=IDLE_LEVEL, serial_valid=0, last=0 and latched order=0, overriding load and shift.
REQ-029 Reset mid-frame SHALL discard the frame, with no further serial_valid until a new accept.
REQ-030 load_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-031 A shared package piso_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the constants MAX_WIDTH=64 and MIN_WIDTH=2.
REQ-032 The bit counter SHALL be a sub-module bit_counter, parametrised by a modulus and carrying increment, clear and terminal-count outputs.
REQ-033 The design SHALL elaborate-time check that WIDTH is within MIN_WIDTH..MAX_WIDTH.

Verification
REQ-034 WIDTH=4, LSB first, accept 4'b0100 then shift=1 held -> serial_out 0,0,1,0 on four consecutive serial_valid cycles, last=1 on the fourth bit only.
REQ-035 WIDTH=4, MSB first, accept 4'b0100 -> serial_out 0,1,0,0; then busy=0 and load_ready=1.
REQ-036 WIDTH=8, accept 8'hA5 LSB first, drop shift for 3 cycles after the 2nd bit -> serial_valid=0 during the stall, serial_out held, and the full stream equals 1,0,1,0,0,1,0,1.
REQ-037 WIDTH=4, accept 4'hF and 4'h0 back-to-back on the final-bit cycle -> eight contiguous serial_valid bits 1,1,1,1,0,0,0,0, with last on the 4th and 8th bits.
REQ-038 WIDTH=4, assert load with 4'h3 mid-frame (load_ready=0) -> the frame in progress is unchanged and 4'h3 is never emitted.
REQ-039 WIDTH=8, reset after 3 bits -> the next cycle shows serial_valid=0, busy=0, serial_out=IDLE_LEVEL, and a new accept serialises correctly.
